scr_access_arbiter: RTL and testbench

- Shares the single-port screen RAM between the video fetch path and host-CPU register writes.
- Video reads have priority and fixed latency. CPU writes are buffered in a small FIFO and drained in idle slots.
- A starvation counter forces a write slot if video keeps the port busy for too long.
- Sits between the mode controllers' screen-address mux, the host register block and screen_ram, all in the fclock domain.

---
 rtl/scr_pkg.sv | 19 +
 rtl/scr_wr_fifo.sv | 64 ++++++
 rtl/scr_access_arbiter.sv | 152 +++++++++++++++
 tb/tb_scr_access_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr_pkg.sv
// Shared types for the screen-RAM access arbiter: default widths, grant
// and arbitration-state encodings.
package scr_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } arb_st_e;

endpackage

// File: rtl/scr_wr_fifo.sv
// CPU write buffer: synchronous FIFO of {addr,data} entries with registered
// occupancy count and a one-cycle overflow pulse when a push hits a full FIFO.
module scr_wr_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_req,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count_nxt,
  output logic                       empty,
  output logic                       ovf_pulse
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = push_req && !full;
  assign ovf_pulse = push_req && full;
  assign do_pop    = pop && !empty;
  assign rdata     = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !do_pop)
      count_nxt = count + CW'(1);
    else if (!push && do_pop)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/scr_access_arbiter.sv
// Screen RAM port arbiter: video reads win, CPU writes drain from a FIFO in
// idle slots, and a starvation counter forces a write slot when needed.
module scr_access_arbiter
  import scr_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_miss,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_full,
  output logic              cpu_busy,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int FW = ADDR_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;

  arb_st_e           state, state_nxt;
  gnt_e              gnt;
  logic [SW-1:0]     starve, starve_nxt;
  logic [RD_LAT:0]   vld_p;
  logic [FW-1:0]     head;
  logic [CW-1:0]     fifo_cnt_nxt;
  logic              fifo_empty;
  logic              fifo_ovf;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    return (s == {SW{1'b1}}) ? s : s + SW'(1);
  endfunction

  scr_wr_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_req  (cpu_wr),
    .pop       (gnt == GNT_CPU),
    .wdata     ({cpu_addr, cpu_data}),
    .rdata     (head),
    .count_nxt (fifo_cnt_nxt),
    .empty     (fifo_empty),
    .ovf_pulse (fifo_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_ARB;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    case (state)
      ST_FORCE: begin
        state_nxt  = ST_ARB;
        starve_nxt = '0;
      end
      default: begin
        if (vid_req) begin
          if (!fifo_empty) begin
            starve_nxt = sat_inc(starve);
            if (starve == SW'(STARVE_MAX - 1))
              state_nxt = ST_FORCE;
          end else begin
            starve_nxt = '0;
          end
        end else if (!fifo_empty) begin
          starve_nxt = '0;
        end
      end
    endcase
  end

  always_comb begin
    gnt      = GNT_NONE;
    vid_miss = 1'b0;
    case (state)
      ST_FORCE: begin
        gnt      = GNT_CPU;
        vid_miss = vid_req;
      end
      default: begin
        if (vid_req)
          gnt = GNT_VID;
        else if (!fifo_empty)
          gnt = GNT_CPU;
      end
    endcase
  end

  // Stage p0: register the granted operation onto the RAM port; track read validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      vld_p     <= '0;
      cpu_full  <= 1'b0;
      cpu_busy  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (gnt)
        GNT_VID: begin
          ram_addr <= vid_addr;
          ram_we   <= 1'b0;
        end
        GNT_CPU: begin
          ram_addr  <= head[FW-1:DATA_W];
          ram_wdata <= head[DATA_W-1:0];
          ram_we    <= 1'b1;
        end
        default: ram_we <= 1'b0;
      endcase
      vld_p    <= (vld_p << 1) | (RD_LAT + 1)'(gnt == GNT_VID);
      cpu_full <= (fifo_cnt_nxt == CW'(FIFO_DEPTH));
      cpu_busy <= (fifo_cnt_nxt != '0) || (gnt == GNT_CPU);
      if (fifo_ovf)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // Stage p1..pRD_LAT: RAM output returns directly, qualified by the valid pipe.
  assign vid_valid = vld_p[RD_LAT];
  assign vid_data  = vid_valid ? ram_q : '0;

endmodule

// File: tb/tb_scr_access_arbiter.sv
// Randomized bench for scr_access_arbiter against a queue-based reference
// model of the arbitration rules, with a behavioural screen RAM attached.
module tb_scr_access_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              vid_miss;
  logic              cpu_wr = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic              cpu_full;
  logic              cpu_busy;
  logic              ovf;
  logic              ovf_clr = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q = '0;

  scr_access_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_valid (vid_valid),
    .vid_data  (vid_data),
    .vid_miss  (vid_miss),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_full  (cpu_full),
    .cpu_busy  (cpu_busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  // Screen RAM: one-cycle registered read, synchronous write.
  logic [DATA_W-1:0] mem    [0:65535];
  logic [DATA_W-1:0] shadow [0:65535];

  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] d;
  } rd_t;

  wr_t fq[$];
  rd_t rq[$];
  int  starve_run;
  bit  force_due;
  int  cyc;
  bit                e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  bit                e_full, e_busy, e_ovf;
  int  n_vec;
  int  n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    fq.delete();
    rq.delete();
    starve_run = 0;
    force_due  = 1'b0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_full = 1'b0; e_busy = 1'b0; e_ovf = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model.
  task automatic step(input bit vr, input logic [ADDR_W-1:0] va, input bit w,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input bit clr);
    int  n_old;
    bit  cpu_gnt;
    bit  exp_valid;
    bit  dropped;
    wr_t e;
    @(posedge clk);
    #1;
    vid_req = vr; vid_addr = va;
    cpu_wr = w; cpu_addr = wa; cpu_data = wd;
    ovf_clr = clr;
    @(negedge clk);
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
    exp_valid = (rq.size() > 0 && rq[0].due == cyc);
    check_val("vid_valid", vid_valid, exp_valid);
    if (exp_valid) begin
      check_val("vid_data", vid_data, rq[0].d);
      void'(rq.pop_front());
    end else begin
      check_val("vid_data_idle", vid_data, 0);
    end
    check_val("vid_miss", vid_miss, force_due && vr);
    check_val("ram_we", ram_we, e_we);
    check_val("ram_addr", ram_addr, e_addr);
    check_val("ram_wdata", ram_wdata, e_wdata);
    check_val("cpu_full", cpu_full, e_full);
    check_val("cpu_busy", cpu_busy, e_busy);
    check_val("ovf", ovf, e_ovf);

    n_old   = fq.size();
    cpu_gnt = 1'b0;
    dropped = 1'b0;
    if (force_due) begin
      cpu_gnt    = 1'b1;
      force_due  = 1'b0;
      starve_run = 0;
    end else if (vr) begin
      e_we   = 1'b0;
      e_addr = va;
      rq.push_back('{due: cyc + 1 + RD_LAT, d: shadow[va]});
      if (n_old > 0) begin
        starve_run++;
        if (starve_run == STARVE_MAX) force_due = 1'b1;
      end else begin
        starve_run = 0;
      end
    end else if (n_old > 0) begin
      cpu_gnt    = 1'b1;
      starve_run = 0;
    end else begin
      e_we = 1'b0;
    end
    if (cpu_gnt) begin
      e = fq.pop_front();
      e_we = 1'b1; e_addr = e.a; e_wdata = e.d;
      shadow[e.a] = e.d;
    end
    if (w) begin
      if (n_old < FIFO_DEPTH) fq.push_back('{a: wa, d: wd});
      else dropped = 1'b1;
    end
    if (dropped) e_ovf = 1'b1;
    else if (clr) e_ovf = 1'b0;
    e_full = (fq.size() == FIFO_DEPTH);
    e_busy = (fq.size() > 0) || cpu_gnt;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    vid_req = 1'b0; cpu_wr = 1'b0; ovf_clr = 1'b0;
    #1;
    check_val("rst_vid_valid", vid_valid, 0);
    check_val("rst_ram_we", ram_we, 0);
    check_val("rst_cpu_busy", cpu_busy, 0);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    check_val("rst_ram_addr", ram_addr, 0);
    check_val("rst_ram_wdata", ram_wdata, 0);
    check_val("rst_cpu_full", cpu_full, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_vid_miss", vid_miss, 0);
    check_val("rst_vid_data", vid_data, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'(i);
      shadow[i] = 8'(i);
    end
    model_clear();

    do_reset(3);
    idle(5);

    // Back-to-back video reads 0x0100..0x0104
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, '0, '0, 1'b0);
    idle(4);

    // Idle-slot drain, then read both locations back
    step(1'b0, '0, 1'b1, 16'h0010, 8'hAA, 1'b0);
    step(1'b0, '0, 1'b1, 16'h0011, 8'hBB, 1'b0);
    idle(4);
    step(1'b1, 16'h0010, 1'b0, '0, '0, 1'b0);
    step(1'b1, 16'h0011, 1'b0, '0, '0, 1'b0);
    idle(3);

    // Overflow with video holding the port, then ovf_clr, then clear racing a new drop
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'h0300 + 16'(i), 1'b1, 16'h0020 + 16'(i), 8'h60 + 8'(i), 1'b0);
    step(1'b1, 16'h0305, 1'b0, '0, '0, 1'b1);
    step(1'b1, 16'h0306, 1'b1, 16'h0030, 8'h70, 1'b1);
    step(1'b1, 16'h0307, 1'b1, 16'h0031, 8'h71, 1'b1);
    idle(8);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(2);

    // Starvation: one write against continuous video
    step(1'b1, 16'h0400, 1'b1, 16'h0200, 8'h55, 1'b0);
    for (int i = 1; i < 16; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0, '0, '0, 1'b0);
    step(1'b1, 16'h0200, 1'b0, '0, '0, 1'b0);
    idle(4);

    // Random traffic in segments of differing video density
    for (int seg = 0; seg < 6; seg++) begin
      int vpct;
      int wpct;
      vpct = (seg % 3 == 0) ? 95 : (seg % 3 == 1) ? 60 : 25;
      wpct = (seg % 2 == 0) ? 50 : 20;
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(99) < vpct), 16'($urandom_range(31)),
             ($urandom_range(99) < wpct), 16'($urandom_range(31)),
             8'($urandom), ($urandom_range(15) == 0));
      end
    end
    idle(6);

    // Reset mid-operation with writes queued and reads in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h0500 + 16'(i), 1'b1, 16'h0040 + 16'(i), 8'hC0 + 8'(i), 1'b0);
    do_reset(3);
    idle(6);
    step(1'b1, 16'h0040, 1'b0, '0, '0, 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
